// File: rtl/cond_flag_scoreboard.sv
// NZCV scoreboard: holds architectural flags, counts in-flight flag writers,
// stalls conditional issue until flags are final, and registers execute/squash.
module cond_flag_scoreboard #(
   parameter int MAX_PENDING = 4,
   parameter bit AL_BYPASS   = 1'b1,
   localparam int CW         = $clog2(MAX_PENDING + 1)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          in_valid,
   input  logic [3:0]    in_cond,
   input  logic          in_set_flags,
   output logic          in_ready,
   input  logic          wb_valid,
   input  logic [3:0]    wb_flags,
   input  logic          flush,
   output logic          out_valid,
   output logic          out_exec,
   output logic [3:0]    status_q,
   output logic [CW-1:0] pending_cnt,
   output logic          err_underflow
);

   localparam logic [CW-1:0] MAX_CNT = CW'(MAX_PENDING);

   logic [3:0]    r_status_p0;
   logic [CW-1:0] r_cnt_p0;
   logic          r_err_p0;
   logic          vld_p1;
   logic          r_exec_p1;

   logic [3:0]    w_eff;
   logic          w_pass;
   logic          w_dep_ok;
   logic          w_cap_ok;
   logic          w_accept;
   logic          w_inc;
   logic          w_dec;

   function automatic logic cond_pass(input logic [3:0] cond, input logic [3:0] f);
      logic n, z, c, v;
      n = f[3];
      z = f[2];
      c = f[1];
      v = f[0];
      case (cond)
         4'b0000: cond_pass = z;
         4'b0001: cond_pass = !z;
         4'b0010: cond_pass = c;
         4'b0011: cond_pass = !c;
         4'b0100: cond_pass = n;
         4'b0101: cond_pass = !n;
         4'b0110: cond_pass = v;
         4'b0111: cond_pass = !v;
         4'b1000: cond_pass = c & !z;
         4'b1001: cond_pass = !c | z;
         4'b1010: cond_pass = (n == v);
         4'b1011: cond_pass = (n != v);
         4'b1100: cond_pass = !z & (n == v);
         4'b1101: cond_pass = z | (n != v);
         4'b1110: cond_pass = 1'b1;
         default: cond_pass = 1'b0;
      endcase
   endfunction

   // Issue stage: writeback bypass makes the flags visible in the cycle they land
   assign w_eff    = wb_valid ? wb_flags : r_status_p0;
   assign w_pass   = cond_pass(in_cond, w_eff);
   assign w_dep_ok = (r_cnt_p0 == '0) || ((r_cnt_p0 == CW'(1)) && wb_valid) ||
                     (AL_BYPASS && (in_cond == 4'b1110));
   assign w_cap_ok = !in_set_flags || (r_cnt_p0 < MAX_CNT) || wb_valid;
   assign in_ready = !rst && !flush && w_dep_ok && w_cap_ok;
   assign w_accept = in_valid && in_ready;
   assign w_inc    = w_accept && in_set_flags && w_pass;
   assign w_dec    = wb_valid && (r_cnt_p0 != '0);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_status_p0 <= '0;
         r_cnt_p0    <= '0;
         r_err_p0    <= 1'b0;
         vld_p1      <= 1'b0;
         r_exec_p1   <= 1'b0;
      end else begin
         vld_p1    <= w_accept;
         r_exec_p1 <= w_accept && w_pass;
         // Writebacks are older than anything a flush kills, so they always land
         if (wb_valid)
            r_status_p0 <= wb_flags;
         if (wb_valid && (r_cnt_p0 == '0) && !w_inc)
            r_err_p0 <= 1'b1;
         if (flush)
            r_cnt_p0 <= '0;
         else
            r_cnt_p0 <= r_cnt_p0 + CW'(w_inc) - CW'(w_dec);
      end
   end

   // Execute stage boundary: registered decision
   assign out_valid     = vld_p1;
   assign out_exec      = r_exec_p1;
   assign status_q      = r_status_p0;
   assign pending_cnt   = r_cnt_p0;
   assign err_underflow = r_err_p0;

endmodule

// File: tb/tb_cond_flag_scoreboard.sv
// Bench for cond_flag_scoreboard: directed scenarios plus a randomized run
// compared against a flag/counter reference model.
module tb_cond_flag_scoreboard;

   localparam int CW = 3;

   logic          clk = 1'b0;
   logic          rst, in_valid, in_set_flags, wb_valid, flush;
   logic [3:0]    in_cond, wb_flags;
   logic          in_ready, out_valid, out_exec, err_underflow;
   logic [3:0]    status_q;
   logic [CW-1:0] pending_cnt;

   int total = 0;
   int bad   = 0;

   cond_flag_scoreboard #(.MAX_PENDING(4), .AL_BYPASS(1'b1)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_cond(in_cond),
      .in_set_flags(in_set_flags), .in_ready(in_ready), .wb_valid(wb_valid),
      .wb_flags(wb_flags), .flush(flush), .out_valid(out_valid), .out_exec(out_exec),
      .status_q(status_q), .pending_cnt(pending_cnt), .err_underflow(err_underflow)
   );

   always #5 clk = ~clk;

   // ARM condition codes come in true/inverted pairs; AL/NV are the exception
   function automatic bit ref_pass(input logic [3:0] c, input logic [3:0] f);
      bit n, z, cy, v, base;
      n = f[3]; z = f[2]; cy = f[1]; v = f[0];
      case (c[3:1])
         3'd0: base = z;
         3'd1: base = cy;
         3'd2: base = n;
         3'd3: base = v;
         3'd4: base = cy && !z;
         3'd5: base = (n == v);
         3'd6: base = !z && (n == v);
         default: base = 1'b1;
      endcase
      if (c[3:1] == 3'd7) return !c[0];
      return c[0] ? !base : base;
   endfunction

   task automatic drive(input bit r, input bit f, input bit iv, input logic [3:0] c,
                        input bit sf, input bit wv, input logic [3:0] wf);
      rst = r; flush = f; in_valid = iv; in_cond = c; in_set_flags = sf;
      wb_valid = wv; wb_flags = wf;
      #1;
   endtask

   task automatic idle();
      drive(0, 0, 0, 4'h0, 0, 0, 4'h0);
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      drive(1, 0, 0, 4'h0, 0, 0, 4'h0);
      tick();
      idle();
   endtask

   task automatic test_reset();
      drive(1, 0, 1, 4'hE, 1, 0, 4'h0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_ready got=%b exp=0", in_ready); end
      tick();
      idle();
      total++;
      if ({out_valid, out_exec, status_q, pending_cnt, err_underflow} !== '0) begin
         bad++;
         $display("FAIL reset_state got=%b%b %h %0d %b exp=all zero", out_valid, out_exec, status_q, pending_cnt, err_underflow);
      end
   endtask

   task automatic test_basic();
      do_reset();
      drive(0, 0, 1, 4'h0, 0, 0, 4'h0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL basic_ready got=%b exp=1", in_ready); end
      tick();
      idle();
      total++; if ({out_valid, out_exec} !== 2'b10) begin bad++; $display("FAIL basic_eq_z0 got=%b%b exp=10", out_valid, out_exec); end
      drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
      tick();
      drive(0, 0, 0, 4'h0, 0, 1, 4'b0100);
      tick();
      total++; if (status_q !== 4'b0100) begin bad++; $display("FAIL basic_status got=%b exp=0100", status_q); end
      drive(0, 0, 1, 4'h0, 0, 0, 4'h0);
      tick();
      idle();
      total++; if ({out_valid, out_exec} !== 2'b11) begin bad++; $display("FAIL basic_eq_z1 got=%b%b exp=11", out_valid, out_exec); end
      total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL basic_err got=%b exp=0", err_underflow); end
   endtask

   task automatic test_bypass();
      do_reset();
      drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
      tick();
      total++; if (pending_cnt !== 3'd1) begin bad++; $display("FAIL byp_cnt1 got=%0d exp=1", pending_cnt); end
      drive(0, 0, 1, 4'h1, 0, 0, 4'h0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL byp_stall got=%b exp=0", in_ready); end
      tick();
      drive(0, 0, 1, 4'h1, 0, 1, 4'b0100);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL byp_ready got=%b exp=1", in_ready); end
      tick();
      idle();
      total++; if ({out_valid, out_exec} !== 2'b10) begin bad++; $display("FAIL byp_exec got=%b%b exp=10", out_valid, out_exec); end
      total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL byp_cnt0 got=%0d exp=0", pending_cnt); end
      total++; if (status_q !== 4'b0100) begin bad++; $display("FAIL byp_status got=%b exp=0100", status_q); end
   endtask

   task automatic test_capacity();
      do_reset();
      for (int i = 0; i < 4; i++) begin
         drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
         total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cap_ready%0d got=%b exp=1", i, in_ready); end
         tick();
      end
      total++; if (pending_cnt !== 3'd4) begin bad++; $display("FAIL cap_cnt4 got=%0d exp=4", pending_cnt); end
      drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL cap_full got=%b exp=0", in_ready); end
      tick();
      drive(0, 0, 1, 4'hE, 1, 1, 4'h0);
      total++; if (in_ready !== 1'b1) begin bad++; $display("FAIL cap_wb_ready got=%b exp=1", in_ready); end
      tick();
      idle();
      total++; if (pending_cnt !== 3'd4) begin bad++; $display("FAIL cap_hold got=%0d exp=4", pending_cnt); end
      total++; if (out_valid !== 1'b1) begin bad++; $display("FAIL cap_out got=%b exp=1", out_valid); end
   endtask

   task automatic test_fail_setter();
      do_reset();
      drive(0, 0, 1, 4'h0, 1, 0, 4'h0);
      tick();
      idle();
      total++; if ({out_valid, out_exec} !== 2'b10) begin bad++; $display("FAIL fset_exec got=%b%b exp=10", out_valid, out_exec); end
      total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL fset_cnt got=%0d exp=0", pending_cnt); end
      for (int f = 0; f < 16; f++) begin
         drive(0, 0, 1, 4'hF, 0, 1, 4'(f));
         tick();
         total++;
         if ({out_valid, out_exec} !== 2'b10) begin
            bad++; $display("FAIL nv_flags%0d got=%b%b exp=10", f, out_valid, out_exec);
         end
      end
      idle();
   endtask

   task automatic test_flush();
      do_reset();
      for (int i = 0; i < 3; i++) begin
         drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
         tick();
      end
      total++; if (pending_cnt !== 3'd3) begin bad++; $display("FAIL fl_cnt3 got=%0d exp=3", pending_cnt); end
      drive(0, 1, 1, 4'hE, 0, 1, 4'b1001);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL fl_ready got=%b exp=0", in_ready); end
      tick();
      idle();
      total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL fl_cnt got=%0d exp=0", pending_cnt); end
      total++; if (status_q !== 4'b1001) begin bad++; $display("FAIL fl_status got=%b exp=1001", status_q); end
      total++; if (out_valid !== 1'b0) begin bad++; $display("FAIL fl_outv got=%b exp=0", out_valid); end
      total++; if (err_underflow !== 1'b0) begin bad++; $display("FAIL fl_err got=%b exp=0", err_underflow); end
   endtask

   task automatic test_underflow_reset();
      do_reset();
      drive(0, 0, 0, 4'h0, 0, 1, 4'b0011);
      tick();
      idle();
      total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_set got=%b exp=1", err_underflow); end
      total++; if (status_q !== 4'b0011) begin bad++; $display("FAIL uf_status got=%b exp=0011", status_q); end
      total++; if (pending_cnt !== 3'd0) begin bad++; $display("FAIL uf_cnt got=%0d exp=0", pending_cnt); end
      drive(0, 0, 1, 4'hE, 1, 0, 4'h0);
      tick();
      drive(0, 0, 1, 4'h0, 0, 0, 4'h0);
      tick();
      total++; if (err_underflow !== 1'b1) begin bad++; $display("FAIL uf_sticky got=%b exp=1", err_underflow); end
      drive(1, 0, 1, 4'h0, 0, 0, 4'h0);
      total++; if (in_ready !== 1'b0) begin bad++; $display("FAIL rst_stall_ready got=%b exp=0", in_ready); end
      tick();
      idle();
      total++;
      if ({out_valid, out_exec, status_q, pending_cnt, err_underflow} !== '0) begin
         bad++;
         $display("FAIL rst_stall got=%b%b %h %0d %b exp=all zero", out_valid, out_exec, status_q, pending_cnt, err_underflow);
      end
   endtask

   task automatic test_random();
      int   m_cnt;
      bit   m_err, m_ov, m_oe;
      logic [3:0] m_status;
      bit   r, f, iv, sf, wv, rdy, pass, acc, inc;
      logic [3:0] c, wf;
      do_reset();
      m_cnt = 0; m_err = 0; m_ov = 0; m_oe = 0; m_status = 4'h0;
      for (int n = 0; n < 600; n++) begin
         r  = ($urandom % 64) == 0;
         f  = ($urandom % 16) == 0;
         iv = ($urandom % 4) != 0;
         c  = (($urandom % 3) == 0) ? 4'hE : 4'($urandom);
         sf = ($urandom % 2) == 0;
         wv = (($urandom % 3) == 0) && ((m_cnt > 0) || (($urandom % 8) == 0));
         wf = 4'($urandom);
         drive(r, f, iv, c, sf, wv, wf);
         rdy = !r && !f &&
               ((m_cnt == 0) || (m_cnt == 1 && wv) || (c == 4'hE)) &&
               (!sf || m_cnt < 4 || wv);
         total++;
         if (in_ready !== rdy) begin bad++; $display("FAIL rnd_ready[%0d] got=%b exp=%b", n, in_ready, rdy); end
         pass = ref_pass(c, wv ? wf : m_status);
         acc  = iv && rdy;
         inc  = acc && sf && pass;
         if (r) begin
            m_cnt = 0; m_err = 0; m_ov = 0; m_oe = 0; m_status = 4'h0;
         end else begin
            m_ov = acc;
            m_oe = acc && pass;
            if (wv && m_cnt == 0 && !inc) m_err = 1;
            if (wv) m_status = wf;
            if (f) m_cnt = 0;
            else m_cnt = m_cnt + int'(inc) - int'(wv && m_cnt > 0);
         end
         tick();
         total++;
         if ({out_valid, out_exec} !== {m_ov, m_oe}) begin
            bad++; $display("FAIL rnd_out[%0d] got=%b%b exp=%b%b", n, out_valid, out_exec, m_ov, m_oe);
         end
         total++;
         if (status_q !== m_status) begin bad++; $display("FAIL rnd_status[%0d] got=%b exp=%b", n, status_q, m_status); end
         total++;
         if (pending_cnt !== 3'(m_cnt)) begin bad++; $display("FAIL rnd_cnt[%0d] got=%0d exp=%0d", n, pending_cnt, m_cnt); end
         total++;
         if (err_underflow !== m_err) begin bad++; $display("FAIL rnd_err[%0d] got=%b exp=%b", n, err_underflow, m_err); end
      end
      idle();
   endtask

   initial begin
      idle();
      test_reset();
      test_basic();
      test_bypass();
      test_capacity();
      test_fail_setter();
      test_flush();
      test_underflow_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
